// File: rtl/timestamp_pkg.sv
// Shared constants, word layout and assembly FSM state for the timestamp word path.
package timestamp_pkg;
   localparam int ID_W      = 4;
   localparam int TYPE_W    = 4;
   localparam int PAYLOAD_W = 24;
   localparam int TS_W      = 64;

   localparam logic [TYPE_W-1:0] TS_TYPE_LO  = 4'h1;
   localparam logic [TYPE_W-1:0] TS_TYPE_MID = 4'h2;
   localparam logic [TYPE_W-1:0] TS_TYPE_HI  = 4'h3;

   typedef enum logic [1:0] {
      ST_W1,
      ST_W2,
      ST_W3,
      ST_OUT
   } asm_state_e;

   typedef struct packed {
      logic [ID_W-1:0]      id;
      logic [TYPE_W-1:0]    typ;
      logic [PAYLOAD_W-1:0] payload;
   } fifo_word_t;
endpackage

// File: rtl/timestamp_word_assembler_if.sv
// FIFO pop port plus the outgoing 64-bit timestamp stream.
interface timestamp_word_assembler_if;
   logic                         FIFO_EMPTY;
   logic                         FIFO_READ;
   logic [31:0]                  FIFO_DATA;
   logic [timestamp_pkg::TS_W-1:0] TS_DATA;
   logic                         TS_VALID;
   logic                         TS_READY;
`ifdef TS_MONOTONIC_CHECK_EN
   logic                         TS_NONMONO;

   modport master (
      input  FIFO_EMPTY, FIFO_DATA, TS_READY,
      output FIFO_READ, TS_DATA, TS_VALID, TS_NONMONO
   );
   modport slave (
      output FIFO_EMPTY, FIFO_DATA, TS_READY,
      input  FIFO_READ, TS_DATA, TS_VALID, TS_NONMONO
   );
`else
   modport master (
      input  FIFO_EMPTY, FIFO_DATA, TS_READY,
      output FIFO_READ, TS_DATA, TS_VALID
   );
   modport slave (
      output FIFO_EMPTY, FIFO_DATA, TS_READY,
      input  FIFO_READ, TS_DATA, TS_VALID
   );
`endif
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over a same-cycle increment.
module sat_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/timestamp_word_assembler.sv
// Pops id/type-tagged words and rebuilds 64-bit timestamps from type 1/2/3 triples.
// Optional macro TS_MONOTONIC_CHECK_EN adds TS_NONMONO (new timestamp <= last emitted).
module timestamp_word_assembler
   import timestamp_pkg::*;
#(
   parameter logic [ID_W-1:0] IDENTIFIER = 4'b0001,
   parameter int              CNT_WIDTH  = 8
) (
   input  logic                       BUS_CLK,
   input  logic                       BUS_RST,
   timestamp_word_assembler_if.master bus,
   input  logic                       CLR_CNT,
   output logic [CNT_WIDTH-1:0]       ID_ERR_CNT,
   output logic [CNT_WIDTH-1:0]       SEQ_ERR_CNT,
   output logic                       BUSY
);
   asm_state_e             state_q, state_d;
   logic                   rd_pend_q, rd_pend_d;
   logic [2*PAYLOAD_W-1:0] part_q, part_d;
   logic [TS_W-1:0]        ts_q, ts_d;
   fifo_word_t             word;
   logic                   fifo_read, handshake, id_err, seq_err;

   assign word      = bus.FIFO_DATA;
   assign handshake = (state_q == ST_OUT) && bus.TS_READY;
   // Combinational pop so the word lands exactly one cycle after the strobe.
   assign fifo_read = !BUS_RST && !bus.FIFO_EMPTY && !rd_pend_q && (state_q != ST_OUT);

   always_comb begin
      state_d   = state_q;
      part_d    = part_q;
      ts_d      = ts_q;
      rd_pend_d = fifo_read;
      id_err    = 1'b0;
      seq_err   = 1'b0;
      if (handshake) begin
         state_d = ST_W1;
      end else if (rd_pend_q) begin
         if (word.id != IDENTIFIER) begin
            id_err = 1'b1;
         end else begin
            case (state_q)
               ST_W1: begin
                  if (word.typ == TS_TYPE_LO) begin
                     part_d[PAYLOAD_W-1:0] = word.payload;
                     state_d = ST_W2;
                  end else begin
                     seq_err = 1'b1;
                  end
               end
               ST_W2: begin
                  if (word.typ == TS_TYPE_MID) begin
                     part_d[2*PAYLOAD_W-1:PAYLOAD_W] = word.payload;
                     state_d = ST_W3;
                  end else if (word.typ == TS_TYPE_LO) begin
                     seq_err = 1'b1;
                     part_d[PAYLOAD_W-1:0] = word.payload;
                  end else begin
                     seq_err = 1'b1;
                     state_d = ST_W1;
                  end
               end
               ST_W3: begin
                  if (word.typ == TS_TYPE_HI && word.payload[PAYLOAD_W-1:16] == '0) begin
                     ts_d    = {word.payload[15:0], part_q};
                     state_d = ST_OUT;
                  end else if (word.typ == TS_TYPE_LO) begin
                     seq_err = 1'b1;
                     part_d[PAYLOAD_W-1:0] = word.payload;
                     state_d = ST_W2;
                  end else begin
                     seq_err = 1'b1;
                     state_d = ST_W1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state_q   <= ST_W1;
         rd_pend_q <= 1'b0;
         part_q    <= '0;
         ts_q      <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
         part_q    <= part_d;
         ts_q      <= ts_d;
      end
   end

`ifdef TS_MONOTONIC_CHECK_EN
   logic [TS_W-1:0] last_q, last_d;
   logic            nonmono_q, nonmono_d;

   always_comb begin
      last_d    = last_q;
      nonmono_d = nonmono_q;
      if (handshake)
         last_d = ts_q;
      if (state_q != ST_OUT && state_d == ST_OUT)
         nonmono_d = (ts_d <= last_q);
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         last_q    <= '0;
         nonmono_q <= 1'b0;
      end else begin
         last_q    <= last_d;
         nonmono_q <= nonmono_d;
      end
   end

   assign bus.TS_NONMONO = nonmono_q;
`endif

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_id_cnt (
      .clk (BUS_CLK),
      .rst (BUS_RST),
      .clr (CLR_CNT),
      .inc (id_err),
      .cnt (ID_ERR_CNT)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_seq_cnt (
      .clk (BUS_CLK),
      .rst (BUS_RST),
      .clr (CLR_CNT),
      .inc (seq_err),
      .cnt (SEQ_ERR_CNT)
   );

   assign bus.FIFO_READ = fifo_read;
   assign bus.TS_VALID  = (state_q == ST_OUT);
   assign bus.TS_DATA   = ts_q;
   assign BUSY          = (state_q == ST_W2) || (state_q == ST_W3);
endmodule

// File: tb/tb_timestamp_word_assembler.sv
// Directed bench: FIFO model + fill-level reference model of the word reassembly.
module tb_timestamp_word_assembler;
   logic       clk = 1'b0;
   logic       rst;
   logic       clr_cnt;
   logic [7:0] id_cnt, seq_cnt;
   logic       busy;

   timestamp_word_assembler_if bus_if ();

   timestamp_word_assembler #(.IDENTIFIER(4'b0001), .CNT_WIDTH(8)) dut (
      .BUS_CLK     (clk),
      .BUS_RST     (rst),
      .bus         (bus_if),
      .CLR_CNT     (clr_cnt),
      .ID_ERR_CNT  (id_cnt),
      .SEQ_ERR_CNT (seq_cnt),
      .BUSY        (busy)
   );

   always #5 clk = ~clk;

   // upstream FIFO: words written by the stimulus, popped on FIFO_READ
   logic [31:0] mem [0:2047];
   int          push_cnt = 0;
   int          pop_cnt  = 0;
   logic        fifo_empty;
   assign fifo_empty        = (push_cnt == pop_cnt);
   assign bus_if.FIFO_EMPTY = fifo_empty;

   always @(posedge clk) begin
      if (bus_if.FIFO_READ && pop_cnt < push_cnt) begin
         bus_if.FIFO_DATA <= mem[pop_cnt];
         pop_cnt <= pop_cnt + 1;
      end
   end

   // reference model state
   int          n_vec = 0;
   int          n_err = 0;
   int          np;
   logic [23:0] part [2];
   int          id_m, seq_m;
   logic [63:0] exp_q [$];
   logic [63:0] mon_last;
   logic        stall_prev;
   logic [63:0] stall_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      np = 0; id_m = 0; seq_m = 0; mon_last = '0;
      exp_q.delete();
   endtask

   task automatic bump_seq();
      if (seq_m != 255) seq_m++;
   endtask

   // partial timestamp viewed as a list of 0..2 accepted payloads
   task automatic model_word(input logic [31:0] w);
      if (w[31:28] != 4'h1) begin
         if (id_m != 255) id_m++;
      end else if (w[27:24] == 4'h1) begin
         if (np != 0) bump_seq();
         part[0] = w[23:0];
         np = 1;
      end else if (w[27:24] == 4'h2 && np == 1) begin
         part[1] = w[23:0];
         np = 2;
      end else if (w[27:24] == 4'h3 && np == 2 && w[23:16] == 8'h00) begin
         exp_q.push_back({w[15:0], part[1], part[0]});
         np = 0;
      end else begin
         bump_seq();
         np = 0;
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[push_cnt] = w;
      push_cnt++;
      model_word(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int quiet = 0;
      for (int i = 0; i < 3000 && quiet < 4; i++) begin
         @(negedge clk);
         if (fifo_empty && !bus_if.FIFO_READ && !bus_if.TS_VALID) quiet++;
         else quiet = 0;
      end
      if (quiet < 4) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: got busy expected idle", name);
      end
   endtask

   task automatic check_model(input string name);
      check({name, "_id_cnt"}, {56'd0, id_cnt}, 64'(id_m));
      check({name, "_seq_cnt"}, {56'd0, seq_cnt}, 64'(seq_m));
      check({name, "_busy"}, {63'd0, busy}, {63'd0, np != 0});
      check({name, "_pending_ts"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; clr_cnt = 1'b0; bus_if.TS_READY = 1'b1;
      stall_prev = 1'b0; stall_data = '0;
      model_reset();

      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (fifo_empty) check("read_while_empty", {63'd0, bus_if.FIFO_READ}, 64'd0);
               if (bus_if.TS_VALID) check("read_in_out", {63'd0, bus_if.FIFO_READ}, 64'd0);
               if (stall_prev) check("ts_stable", bus_if.TS_DATA, stall_data);
               if (bus_if.TS_VALID && bus_if.TS_READY) begin
                  if (exp_q.size() == 0) begin
                     n_vec++; n_err++;
                     $display("FAIL unexpected_ts: got %h expected none", bus_if.TS_DATA);
                  end else begin
                     logic [63:0] e;
                     e = exp_q.pop_front();
                     check("ts_data", bus_if.TS_DATA, e);
`ifdef TS_MONOTONIC_CHECK_EN
                     check("ts_nonmono", {63'd0, bus_if.TS_NONMONO}, {63'd0, e <= mon_last});
                     mon_last = e;
`endif
                  end
               end
               stall_prev = bus_if.TS_VALID && !bus_if.TS_READY;
               stall_data = bus_if.TS_DATA;
            end else begin
               stall_prev = 1'b0;
            end
         end
      join_none

      // reset state
      repeat (2) @(negedge clk);
      check("rst_fifo_read", {63'd0, bus_if.FIFO_READ}, 64'd0);
      check("rst_ts_valid", {63'd0, bus_if.TS_VALID}, 64'd0);
      check("rst_ts_data", bus_if.TS_DATA, 64'd0);
      check("rst_cnts", {48'd0, id_cnt, seq_cnt}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      tick(); rst = 1'b0;

      // basic triple
      push(32'h11ABCDEF); push(32'h12123456); push(32'h13009876);
      wait_idle("basic");
      check("basic_lit", bus_if.TS_DATA, 64'h9876123456ABCDEF);
      check_model("basic");

      // consumer stall with a second triple queued behind
      tick(); bus_if.TS_READY = 1'b0;
      push(32'h11ABCDEF); push(32'h12123456); push(32'h13009876);
      push(32'h11000010); push(32'h12000020); push(32'h13000030);
      begin
         int k = 0;
         while (!bus_if.TS_VALID && k < 50) begin @(negedge clk); k++; end
         check("stall_valid", {63'd0, bus_if.TS_VALID}, 64'd1);
      end
      repeat (10) @(negedge clk);
      check("stall_hold_lit", bus_if.TS_DATA, 64'h9876123456ABCDEF);
      tick(); bus_if.TS_READY = 1'b1;
      wait_idle("stall");
      check("stall_next_lit", bus_if.TS_DATA, 64'h0030000020000010);
      check_model("stall");

      // restart on a repeated type-1 word
      tick();
      push(32'h11000001); push(32'h11000002); push(32'h12000003); push(32'h13000004);
      wait_idle("restart");
      check("restart_lit", bus_if.TS_DATA, 64'h0004000003000002);
      check("restart_seq_lit", {56'd0, seq_cnt}, 64'd1);
      check_model("restart");

      // foreign word between triple words
      tick();
      push(32'h11000111); push(32'h21000001); push(32'h12000222); push(32'h13000333);
      wait_idle("foreign");
      check("foreign_lit", bus_if.TS_DATA, 64'h0333000222000111);
      check("foreign_id_lit", {56'd0, id_cnt}, 64'd1);
      check_model("foreign");

      // saturation then clear
      tick();
      for (int i = 0; i < 300; i++) push(32'h14000000 | 32'(i));
      wait_idle("sat");
      check("sat_seq_lit", {56'd0, seq_cnt}, 64'd255);
      check_model("sat");
      tick(); clr_cnt = 1'b1;
      id_m = 0; seq_m = 0;
      tick(); clr_cnt = 1'b0;
      @(negedge clk);
      check("clr_cnts", {48'd0, id_cnt, seq_cnt}, 64'd0);

      // bad high byte in W3, type 3 seen in W2
      tick();
      push(32'h11000001); push(32'h12000002); push(32'h13010003);
      push(32'h11000004); push(32'h13000005);
      wait_idle("badhi");
      check("badhi_seq_lit", {56'd0, seq_cnt}, 64'd2);
      check_model("badhi");

      // reset while holding a partial timestamp in W3
      tick();
      push(32'h11000AAA); push(32'h12000BBB);
      wait_idle("partial");
      check("partial_busy_lit", {63'd0, busy}, 64'd1);
      check_model("partial");
      tick(); rst = 1'b1;
      model_reset();
      tick(); tick();
      @(negedge clk);
      check("mid_rst_busy", {63'd0, busy}, 64'd0);
      check("mid_rst_ts_data", bus_if.TS_DATA, 64'd0);
      check("mid_rst_cnts", {48'd0, id_cnt, seq_cnt}, 64'd0);
      tick(); rst = 1'b0;
      push(32'h11000CCC); push(32'h12000DDD); push(32'h13000EEE);
      wait_idle("post_rst");
      check("post_rst_lit", bus_if.TS_DATA, 64'h0EEE000DDD000CCC);
      check_model("post_rst");

`ifdef TS_MONOTONIC_CHECK_EN
      tick();
      push(32'h11000005); push(32'h12000000); push(32'h13000000);
      wait_idle("mono_a");
      push(32'h11000005); push(32'h12000000); push(32'h13000000);
      wait_idle("mono_b");
      check("mono_equal_lit", {63'd0, bus_if.TS_NONMONO}, 64'd1);
      push(32'h11000006); push(32'h12000000); push(32'h13000000);
      wait_idle("mono_c");
      check("mono_incr_lit", {63'd0, bus_if.TS_NONMONO}, 64'd0);
      check_model("mono");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
